// File: rtl/exec_dispatch_pkg.sv
// Shared constants and types for the execute-dispatch stage.
//   W_OPR / W_REG : operand and register-index widths
//   unit_e        : execute unit encodings (UNIT_LOGIC/ARITH/SHIFT/MEM)
//   entry_t       : one held instruction (operands, sources, unit, sel, rd)
//   state_e       : occupancy state, value equals the entry count
package exec_dispatch_pkg;

    localparam int unsigned W_OPR  = 32;
    localparam int unsigned W_REG  = 5;
    localparam int unsigned W_UNIT = 2;
    localparam int unsigned W_SEL  = 2;
    localparam int unsigned W_CNT  = 2;

    typedef enum logic [W_UNIT-1:0] {
        UNIT_LOGIC = 2'd0,
        UNIT_ARITH = 2'd1,
        UNIT_SHIFT = 2'd2,
        UNIT_MEM   = 2'd3
    } unit_e;

    typedef struct packed {
        logic [W_OPR-1:0]  opr0;
        logic [W_OPR-1:0]  opr1;
        logic [W_REG-1:0]  rs0;
        logic [W_REG-1:0]  rs1;
        logic [W_UNIT-1:0] unit;
        logic [W_SEL-1:0]  sel;
        logic [W_REG-1:0]  rd;
    } entry_t;

    typedef enum logic [W_CNT-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/exec_fwd_mux.sv
// Per-operand writeback patch: replaces the operand with the writeback data
// when a valid writeback targets its (non-zero) source register.
// Pass-through when VENUS_EXEC_FWD_EN is not defined.
//   opr, rs             : held operand and its source index
//   wb_valid/wb_rd/data : writeback bus
//   patched_c           : resulting operand (combinational)
module exec_fwd_mux
    import exec_dispatch_pkg::*;
(
    input  logic [W_OPR-1:0] opr,
    input  logic [W_REG-1:0] rs,
    input  logic             wb_valid,
    input  logic [W_REG-1:0] wb_rd,
    input  logic [W_OPR-1:0] wb_data,
    output logic [W_OPR-1:0] patched_c
);

`ifdef VENUS_EXEC_FWD_EN
    logic hit_c;

    // Register 0 is hardwired, never forward into it
    assign hit_c     = wb_valid && (wb_rd != '0) && (wb_rd == rs);
    assign patched_c = hit_c ? wb_data : opr;
`else
    logic unused_c;

    assign patched_c = opr;
    assign unused_c  = ^{rs, wb_valid, wb_rd, wb_data};
`endif

endmodule

// File: rtl/exec_dispatch.sv
// Execute-dispatch stage: two-entry skid buffer between decode and the
// execute units, presenting registered operands/unit/sel/rd.
// Optional operand forwarding from writeback: VENUS_EXEC_FWD_EN.
//   clk_i, rst_ni         : clock, async active-low reset
//   flush_i               : drop all held entries
//   in_*                  : decode-side valid/ready and instruction fields
//   wb_*                  : writeback result bus (used only with forwarding)
//   out_*                 : execute-side valid/ready and staged fields
//   count_o               : occupancy 0..2
module exec_dispatch
    import exec_dispatch_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [W_OPR-1:0]  in_opr0_i,
    input  logic [W_OPR-1:0]  in_opr1_i,
    input  logic [W_REG-1:0]  in_rs0_i,
    input  logic [W_REG-1:0]  in_rs1_i,
    input  logic [W_UNIT-1:0] in_unit_i,
    input  logic [W_SEL-1:0]  in_sel_i,
    input  logic [W_REG-1:0]  in_rd_i,
    input  logic              wb_valid_i,
    input  logic [W_REG-1:0]  wb_rd_i,
    input  logic [W_OPR-1:0]  wb_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [W_OPR-1:0]  out_opr0_o,
    output logic [W_OPR-1:0]  out_opr1_o,
    output logic [W_UNIT-1:0] out_unit_o,
    output logic [W_SEL-1:0]  out_sel_o,
    output logic [W_REG-1:0]  out_rd_o,
    output logic [W_CNT-1:0]  count_o
);

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   ready_q, valid_q;

    entry_t in_c, in_fwd_c, main_fwd_c, skid_fwd_c;
    logic   accept_c, consume_c;

    // Incoming instruction as an entry
    always_comb begin
        in_c      = '0;
        in_c.opr0 = in_opr0_i;
        in_c.opr1 = in_opr1_i;
        in_c.rs0  = in_rs0_i;
        in_c.rs1  = in_rs1_i;
        in_c.unit = in_unit_i;
        in_c.sel  = in_sel_i;
        in_c.rd   = in_rd_i;
    end

    // Operand patching for input, main and skid entries
    exec_fwd_mux u_fwd_in0 (
        .opr(in_c.opr0), .rs(in_c.rs0), .wb_valid(wb_valid_i),
        .wb_rd(wb_rd_i), .wb_data(wb_data_i), .patched_c(in_fwd_c.opr0)
    );
    exec_fwd_mux u_fwd_in1 (
        .opr(in_c.opr1), .rs(in_c.rs1), .wb_valid(wb_valid_i),
        .wb_rd(wb_rd_i), .wb_data(wb_data_i), .patched_c(in_fwd_c.opr1)
    );
    exec_fwd_mux u_fwd_main0 (
        .opr(main_q.opr0), .rs(main_q.rs0), .wb_valid(wb_valid_i),
        .wb_rd(wb_rd_i), .wb_data(wb_data_i), .patched_c(main_fwd_c.opr0)
    );
    exec_fwd_mux u_fwd_main1 (
        .opr(main_q.opr1), .rs(main_q.rs1), .wb_valid(wb_valid_i),
        .wb_rd(wb_rd_i), .wb_data(wb_data_i), .patched_c(main_fwd_c.opr1)
    );
    exec_fwd_mux u_fwd_skid0 (
        .opr(skid_q.opr0), .rs(skid_q.rs0), .wb_valid(wb_valid_i),
        .wb_rd(wb_rd_i), .wb_data(wb_data_i), .patched_c(skid_fwd_c.opr0)
    );
    exec_fwd_mux u_fwd_skid1 (
        .opr(skid_q.opr1), .rs(skid_q.rs1), .wb_valid(wb_valid_i),
        .wb_rd(wb_rd_i), .wb_data(wb_data_i), .patched_c(skid_fwd_c.opr1)
    );

    // Non-operand fields pass through unchanged
    assign in_fwd_c.rs0   = in_c.rs0;
    assign in_fwd_c.rs1   = in_c.rs1;
    assign in_fwd_c.unit  = in_c.unit;
    assign in_fwd_c.sel   = in_c.sel;
    assign in_fwd_c.rd    = in_c.rd;
    assign main_fwd_c.rs0  = main_q.rs0;
    assign main_fwd_c.rs1  = main_q.rs1;
    assign main_fwd_c.unit = main_q.unit;
    assign main_fwd_c.sel  = main_q.sel;
    assign main_fwd_c.rd   = main_q.rd;
    assign skid_fwd_c.rs0  = skid_q.rs0;
    assign skid_fwd_c.rs1  = skid_q.rs1;
    assign skid_fwd_c.unit = skid_q.unit;
    assign skid_fwd_c.sel  = skid_q.sel;
    assign skid_fwd_c.rd   = skid_q.rd;

    assign accept_c  = in_valid_i & ready_q;
    assign consume_c = valid_q & out_ready_i;

    // Next-state and next-entry selection
    always_comb begin
        state_d = state_q;
        main_d  = main_fwd_c;
        skid_d  = skid_fwd_c;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        state_d = ST_ONE;
                        main_d  = in_fwd_c;
                    end
                end
                ST_ONE: begin
                    if (accept_c && consume_c) begin
                        main_d = in_fwd_c;
                    end else if (accept_c) begin
                        state_d = ST_FULL;
                        skid_d  = in_fwd_c;
                    end else if (consume_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (consume_c) begin
                        state_d = ST_ONE;
                        main_d  = skid_fwd_c;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State, entries and handshake flags; flags are decoded from next state
    // so neither ready nor valid has a combinational input path
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= (state_d != ST_FULL);
            valid_q <= (state_d != ST_EMPTY);
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign out_opr0_o  = main_q.opr0;
    assign out_opr1_o  = main_q.opr1;
    assign out_unit_o  = main_q.unit;
    assign out_sel_o   = main_q.sel;
    assign out_rd_o    = main_q.rd;
    assign count_o     = W_CNT'(state_q);

endmodule

// File: tb/tb_exec_dispatch.sv
// Self-checking bench for exec_dispatch: directed table, hand sequences for
// flush / forwarding / mid-stall reset, then randomized traffic against a
// queue-based reference model. Honours VENUS_EXEC_FWD_EN.
module tb_exec_dispatch;
    import exec_dispatch_pkg::*;

`ifdef VENUS_EXEC_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_opr0 = '0, in_opr1 = '0;
    logic [4:0]  in_rs0 = '0, in_rs1 = '0, in_rd = '0;
    logic [1:0]  in_unit = '0, in_sel = '0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_opr0, out_opr1;
    logic [1:0]  out_unit, out_sel;
    logic [4:0]  out_rd;
    logic [1:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    exec_dispatch dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_opr0_i(in_opr0), .in_opr1_i(in_opr1),
        .in_rs0_i(in_rs0), .in_rs1_i(in_rs1),
        .in_unit_i(in_unit), .in_sel_i(in_sel), .in_rd_i(in_rd),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_opr0_o(out_opr0), .out_opr1_o(out_opr1),
        .out_unit_o(out_unit), .out_sel_o(out_sel), .out_rd_o(out_rd),
        .count_o(count)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO of held instructions, head is presented
    typedef struct {
        logic [31:0] opr0, opr1;
        logic [4:0]  rs0, rs1, rd;
        logic [1:0]  unit, sel;
    } ins_t;
    ins_t mq[$];

    function automatic logic [31:0] fwd(logic [31:0] v, logic [4:0] rs);
        if (FWD_ON && wb_valid && wb_rd != 5'd0 && wb_rd == rs) return wb_data;
        return v;
    endfunction

    // Advance the model by one edge using the inputs held across that edge
    task automatic model_step();
        int   n;
        bit   acc, con;
        ins_t x;
        n   = mq.size();
        acc = in_valid && (n < 2);
        con = out_ready && (n > 0);
        foreach (mq[i]) begin
            mq[i].opr0 = fwd(mq[i].opr0, mq[i].rs0);
            mq[i].opr1 = fwd(mq[i].opr1, mq[i].rs1);
        end
        if (flush) begin
            mq.delete();
        end else begin
            if (con) void'(mq.pop_front());
            if (acc) begin
                x.opr0 = fwd(in_opr0, in_rs0);
                x.opr1 = fwd(in_opr1, in_rs1);
                x.rs0 = in_rs0; x.rs1 = in_rs1; x.rd = in_rd;
                x.unit = in_unit; x.sel = in_sel;
                mq.push_back(x);
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        int n;
        n = mq.size();
        chk("m_count", 32'(count), 32'(n));
        chk("m_in_ready", 32'(in_ready), 32'(n < 2));
        chk("m_out_valid", 32'(out_valid), 32'(n > 0));
        if (n > 0) begin
            chk("m_opr0", out_opr0, mq[0].opr0);
            chk("m_opr1", out_opr1, mq[0].opr1);
            chk("m_unit", 32'(out_unit), 32'(mq[0].unit));
            chk("m_sel", 32'(out_sel), 32'(mq[0].sel));
            chk("m_rd", 32'(out_rd), 32'(mq[0].rd));
        end
    endtask

    // One clock: inputs set at negedge, model advanced at posedge, check at next negedge
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        bit          v;
        logic [31:0] o0, o1;
        logic [1:0]  unit, sel;
        bit          ordy;
        int          ecnt;
        bit          eval, erdy;
        logic [31:0] eo0, eo1;
        logic [1:0]  eunit, esel;
    } vec_t;
    vec_t tbl[11];

    initial begin
        // Stream of four with out_ready high, then the stall/skid scenario
        tbl[0]  = '{1, 32'h1, 32'h2, 2'd1, 2'd0, 1, 1, 1, 1, 32'h1, 32'h2, 2'd1, 2'd0};
        tbl[1]  = '{1, 32'h3, 32'h4, 2'd2, 2'd1, 1, 1, 1, 1, 32'h3, 32'h4, 2'd2, 2'd1};
        tbl[2]  = '{1, 32'h5, 32'h6, 2'd3, 2'd2, 1, 1, 1, 1, 32'h5, 32'h6, 2'd3, 2'd2};
        tbl[3]  = '{1, 32'h7, 32'h8, 2'd1, 2'd3, 1, 1, 1, 1, 32'h7, 32'h8, 2'd1, 2'd3};
        tbl[4]  = '{0, 32'h0, 32'h0, 2'd0, 2'd0, 1, 0, 0, 1, 32'h0, 32'h0, 2'd0, 2'd0};
        tbl[5]  = '{1, 32'h0000_00F0, 32'h0000_0F0F, 2'd0, 2'd3, 0, 1, 1, 1,
                    32'h0000_00F0, 32'h0000_0F0F, 2'd0, 2'd3};
        tbl[6]  = '{1, 32'hAA, 32'h55, 2'd1, 2'd1, 0, 2, 1, 0,
                    32'h0000_00F0, 32'h0000_0F0F, 2'd0, 2'd3};
        tbl[7]  = '{1, 32'hAA, 32'h55, 2'd1, 2'd1, 0, 2, 1, 0,
                    32'h0000_00F0, 32'h0000_0F0F, 2'd0, 2'd3};
        tbl[8]  = '{1, 32'hAA, 32'h55, 2'd1, 2'd1, 0, 2, 1, 0,
                    32'h0000_00F0, 32'h0000_0F0F, 2'd0, 2'd3};
        tbl[9]  = '{0, 32'h0, 32'h0, 2'd0, 2'd0, 1, 1, 1, 1, 32'hAA, 32'h55, 2'd1, 2'd1};
        tbl[10] = '{0, 32'h0, 32'h0, 2'd0, 2'd0, 1, 0, 0, 1, 32'h0, 32'h0, 2'd0, 2'd0};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_opr0", out_opr0, 32'd0);
        chk("rst_opr1", out_opr1, 32'd0);
        chk("rst_fields", 32'({out_unit, out_sel, out_rd}), 32'd0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            in_valid = tbl[i].v; in_opr0 = tbl[i].o0; in_opr1 = tbl[i].o1;
            in_unit = tbl[i].unit; in_sel = tbl[i].sel;
            in_rs0 = 5'd1; in_rs1 = 5'd2; in_rd = 5'(i);
            out_ready = tbl[i].ordy;
            step();
            chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].ecnt));
            chk($sformatf("t%0d_valid", i), 32'(out_valid), 32'(tbl[i].eval));
            chk($sformatf("t%0d_ready", i), 32'(in_ready), 32'(tbl[i].erdy));
            if (tbl[i].eval) begin
                chk($sformatf("t%0d_opr0", i), out_opr0, tbl[i].eo0);
                chk($sformatf("t%0d_opr1", i), out_opr1, tbl[i].eo1);
                chk($sformatf("t%0d_unit", i), 32'(out_unit), 32'(tbl[i].eunit));
                chk($sformatf("t%0d_sel", i), 32'(out_sel), 32'(tbl[i].esel));
            end
        end

        // Flush from FULL with an instruction offered
        out_ready = 1'b0; in_valid = 1'b1; in_opr0 = 32'h10; in_opr1 = 32'h20;
        step();
        in_opr0 = 32'h30; in_opr1 = 32'h40;
        step();
        chk("fl_pre_count", 32'(count), 32'd2);
        flush = 1'b1; out_ready = 1'b1; in_opr0 = 32'h6666; in_opr1 = 32'h7777;
        step();
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        flush = 1'b0; in_valid = 1'b0;
        repeat (2) begin
            step();
            chk("fl_dropped", 32'(out_valid), 32'd0);
        end

        // Forwarding into an incoming instruction, then into a stalled main
        out_ready = 1'b0; in_valid = 1'b1;
        in_opr0 = 32'h11; in_opr1 = 32'h22; in_rs0 = 5'd3; in_rs1 = 5'd7;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
        step();
        chk("fw_in_opr0", out_opr0, FWD_ON ? 32'hDEAD_BEEF : 32'h11);
        chk("fw_in_opr1", out_opr1, 32'h22);
        in_valid = 1'b0; wb_rd = 5'd7; wb_data = 32'h1234;
        step();
        chk("fw_main_opr1", out_opr1, FWD_ON ? 32'h1234 : 32'h22);
        chk("fw_main_opr0", out_opr0, FWD_ON ? 32'hDEAD_BEEF : 32'h11);
        wb_valid = 1'b0; out_ready = 1'b1;
        step();
        // Register 0 never forwards
        out_ready = 1'b0; in_valid = 1'b1;
        in_opr0 = 32'h55; in_opr1 = 32'h66; in_rs0 = 5'd0; in_rs1 = 5'd0;
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        step();
        chk("fw_r0_opr0", out_opr0, 32'h55);
        chk("fw_r0_opr1", out_opr1, 32'h66);
        in_valid = 1'b0; wb_valid = 1'b0; out_ready = 1'b1;
        step();

        // Asynchronous reset while FULL and stalled
        out_ready = 1'b0; in_valid = 1'b1; in_opr0 = 32'h99;
        step();
        step();
        chk("rs_pre_count", 32'(count), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rs_valid_now", 32'(out_valid), 32'd0);
        chk("rs_count_now", 32'(count), 32'd0);
        mq.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rs_ready", 32'(in_ready), 32'd1);
        chk("rs_count", 32'(count), 32'd0);
        @(negedge clk);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_opr0   = $urandom;
            in_opr1   = $urandom;
            in_rs0    = 5'($urandom_range(0, 7));
            in_rs1    = 5'($urandom_range(0, 7));
            in_rd     = 5'($urandom_range(0, 31));
            in_unit   = 2'($urandom_range(0, 3));
            in_sel    = 2'($urandom_range(0, 3));
            wb_valid  = ($urandom_range(0, 1) != 0);
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_dispatch.md
# exec_dispatch

Pipeline register and operand-staging stage directly upstream of the execute units (logic, arithmetic, shift, memory). It accepts one decoded instruction per cycle from decode over a valid/ready handshake. It holds the instruction in a two-entry skid buffer and presents registered operands, unit select and function select to the execute units. With forwarding compiled in, it also patches held operands with in-flight writeback results, so back-to-back dependent instructions execute without waiting on the register file.

## Interface
- W_OPR, 32, operand/result width (shared constant)
- W_REG, 5, register-index width (shared constant)
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all held entries (branch redirect)
- in_valid_i  in  1  decode offers an instruction
- in_ready_o  out  1  stage can accept this cycle
- in_opr0_i, in_opr1_i  in  W_OPR  operands read from register file
- in_rs0_i, in_rs1_i  in  W_REG  source indices of the operands
- in_unit_i  in  2  execute unit: 0 logic, 1 arith, 2 shift, 3 mem
- in_sel_i  in  2  function select within unit (logic: 0 and, 1 or, 2 not, 3 xor)
- in_rd_i  in  W_REG  destination index
- wb_valid_i  in  1  writeback result valid this cycle
- wb_rd_i  in  W_REG  writeback destination
- wb_data_i  in  W_OPR  writeback data
- out_valid_o  out  1  entry presented to execute
- out_ready_i  in  1  execute consumes presented entry
- out_opr0_o, out_opr1_o  out  W_OPR  staged operands
- out_unit_o, out_sel_o  out  2  staged unit/function select
- out_rd_o  out  W_REG  staged destination
- count_o  out  2  occupancy, 0..2

## Operation
- Storage: main entry (drives outputs) and skid entry, each carrying a valid bit and the fields opr0, opr1, rs0, rs1, unit, sel, rd.
- States, encoded by count_o:
  - EMPTY (0)
  - ONE (main valid)
  - FULL (main and skid valid)
- Accept = in_valid_i & in_ready_o. Consume = out_valid_o & out_ready_i.
- EMPTY:
  - accept -> ONE, main loaded.
- ONE:
  - accept without consume -> FULL, skid loaded.
  - accept with consume -> ONE, main reloaded from input.
  - consume only -> EMPTY.
- FULL:
  - in_ready_o = 0.
  - consume -> ONE, skid moves to main.
  - otherwise hold.
- in_ready_o = !skid valid. This is a registered condition with no combinational path from out_ready_i.
- out_valid_o = main valid. Outputs come directly from main-entry registers.
- flush_i: both valid bits clear at the next edge. An accept or consume in the same cycle is ignored. In the flush cycle in_ready_o behaves normally, but the accepted instruction is dropped.
- Reset: count_o = 0, out_valid_o = 0, in_ready_o = 1. All data outputs are 0.

## Timing
- Latency: accepted on edge N, out_valid_o is high after edge N.
- Throughput: one instruction per cycle while out_ready_i stays high.
- While out_valid_o & !out_ready_i, all out_* are stable, except forwarding patches (see Configuration).
- Simultaneous accept and consume in FULL is impossible because in_ready_o = 0.
- An asynchronous reset asserted mid-transfer drops both entries immediately.

## Configuration
- VENUS_EXEC_FWD_EN defined:
  - When wb_valid_i, wb_rd_i != 0 and wb_rd_i equals an entry's rs0 or rs1, that operand is replaced by wb_data_i at the next edge.
  - This applies to the main entry, the skid entry, and an instruction being accepted that cycle. An incoming instruction's captured operand uses wb_data_i, not in_opr*_i.
  - If rs0 == rs1, both operands are patched.
  - Index 0 is never forwarded.
- VENUS_EXEC_FWD_EN undefined:
  - wb_* inputs are ignored and operands pass through unchanged.
  - Outputs are strictly stable while stalled.

## Structure
- W_OPR, W_REG and the unit encodings (UNIT_LOGIC, UNIT_ARITH, UNIT_SHIFT, UNIT_MEM) belong in the shared parameter include, next to the existing execute constants.
- Sub-module exec_fwd_mux: combinational per-operand patch. It takes an operand, rs, wb_valid, wb_rd and wb_data, and returns the patched operand. It is instantiated six times (two per entry plus two for the input). It is a pass-through when forwarding is compiled out.

## Test plan
- Reset, then stream 4 instructions with out_ready_i=1 -> out_valid_o one cycle after each accept, same order, in_ready_o constantly 1, count_o <= 1.
- Accept opr0=0x0000_00F0, opr1=0x0000_0F0F, unit=0, sel=3; hold out_ready_i=0 for 3 cycles while offering a second instruction -> count_o=2, in_ready_o=0, outputs stable at the first entry. Then out_ready_i=1 -> the first then the second entry appear on consecutive cycles.
- FULL state plus flush_i=1 with in_valid_i=1 -> next cycle count_o=0, out_valid_o=0, and the offered instruction never appears.
- Forwarding on: accept rs0=3 while wb_valid_i=1, wb_rd_i=3, wb_data_i=0xDEAD_BEEF -> out_opr0_o=0xDEAD_BEEF. A stalled main entry with rs1=7, then wb to rd 7 with value 0x1234 -> out_opr1_o becomes 0x1234 next cycle.
- Forwarding on, wb_rd_i=0 matching rs0=0 -> operand unchanged. Forwarding off, the same stimulus as scenario 4 -> operands unchanged.
- Assert rst_ni low mid-stall with count_o=2 -> out_valid_o drops immediately, in_ready_o=1 and count_o=0 after release.
